// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard/forwarding scoreboard.
package pipe_pkg;

    // Stage indices after ID (default three-stage tail).
    localparam int STG_EXE  = 32'sd0;
    localparam int STG_MEM  = 32'sd1;
    localparam int STG_WB   = 32'sd2;

    // Operand select 0 means "take the register file value".
    localparam int FWD_RF   = 32'sd0;

    // First stage whose pipe register holds the result.
    localparam int RDY_ALU  = 32'sd1;
    localparam int RDY_LOAD = 32'sd2;

    // Forward select code for a result sitting in stage stg.
    function automatic int fwd_code(input int stg);
        return stg + 32'sd1;
    endfunction

endpackage

// File: rtl/sb_src_check.sv
// Per-source priority match against the in-flight entries and the
// resulting hazard flag plus ID / next-EXE forward selects.
module sb_src_check
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int SW     = $clog2(DEPTH),
    parameter int FW     = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0]        ent_valid,
    input  logic [DEPTH*REG_AW-1:0] ent_dst,
    input  logic [DEPTH*SW-1:0]     ent_rdy,
    input  logic [REG_AW-1:0]       src,
    input  logic                    src_en,
    input  logic                    use_id,
    output logic                    hazard,
    output logic [FW-1:0]           fwd_id,
    output logic [FW-1:0]           fwd_ex_nxt
);

    logic hit_s;
    int   hit_k_s;
    int   hit_rdy_s;

    // Find the youngest (lowest stage index) entry writing this source.
    always_comb begin
        hit_s     = 1'b0;
        hit_k_s   = 32'sd0;
        hit_rdy_s = 32'sd0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_valid[k] && src_en && (ent_dst[k*REG_AW +: REG_AW] == src)) begin
                hit_s     = 1'b1;
                hit_k_s   = k;
                hit_rdy_s = int'(ent_rdy[k*SW +: SW]);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Decide hazard or forward select from the governing match.
    always_comb begin
        hazard     = 1'b0;
        fwd_id     = FW'(FWD_RF);
        fwd_ex_nxt = FW'(FWD_RF);
        if (!hit_s) begin
            hazard = 1'b0;
        end else if (FWD_EN == 32'sd0) begin
            // No bypass: wait until the producer has left the pipeline.
            hazard = 1'b1;
        end else if (use_id) begin
            if (hit_k_s < hit_rdy_s) begin
                hazard = 1'b1;
            end else begin
                fwd_id = FW'(fwd_code(hit_k_s));
            end
        end else begin
            // Consumer reaches EXE next cycle, producer will be one stage further.
            if ((hit_k_s + 32'sd1) < hit_rdy_s) begin
                hazard = 1'b1;
            end else if ((hit_k_s + 32'sd1) <= (DEPTH - 32'sd1)) begin
                fwd_ex_nxt = FW'(fwd_code(hit_k_s + 32'sd1));
            end else begin
                fwd_ex_nxt = FW'(FWD_RF);
            end
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard for the stages after ID: tracks in-flight
// destinations, raises the ID stall, produces forward selects and counts stalls.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16,
    localparam int SW     = $clog2(DEPTH),
    localparam int FW     = $clog2(DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_en,
    input  logic [NUM_SRC-1:0]        id_src_use_id,
    input  logic                      id_wr,
    input  logic [REG_AW-1:0]         id_dst,
    input  logic [SW-1:0]             id_rdy_stg,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*FW-1:0]     fwd_id,
    output logic [NUM_SRC*FW-1:0]     fwd_ex,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic [DEPTH-1:0]        ent_valid_r;
    logic [DEPTH*REG_AW-1:0] ent_dst_r;
    logic [DEPTH*SW-1:0]     ent_rdy_r;
    logic [NUM_SRC-1:0]      hazard_s;
    logic [NUM_SRC*FW-1:0]   fwd_ex_nxt_s;
    logic [NUM_SRC*FW-1:0]   fwd_ex_r;
    logic [CNT_W-1:0]        stall_cnt_r;
    logic                    stall_s;
    logic                    load_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            sb_src_check #(
                .REG_AW (REG_AW),
                .DEPTH  (DEPTH),
                .FWD_EN (FWD_EN),
                .SW     (SW),
                .FW     (FW)
            ) u_chk (
                .ent_valid  (ent_valid_r),
                .ent_dst    (ent_dst_r),
                .ent_rdy    (ent_rdy_r),
                .src        (id_src[gi*REG_AW +: REG_AW]),
                .src_en     (id_src_en[gi]),
                .use_id     (id_src_use_id[gi]),
                .hazard     (hazard_s[gi]),
                .fwd_id     (fwd_id[gi*FW +: FW]),
                .fwd_ex_nxt (fwd_ex_nxt_s[gi*FW +: FW])
            );
        end
    endgenerate

    // Stall on any source hazard; a flushed instruction never stalls. Slot 0 load qualifier.
    always_comb begin
        stall_s = id_valid & ~flush & (|hazard_s);
        load_s  = id_valid & id_wr & (id_dst != {REG_AW{1'b0}}) & ~stall_s & ~flush;
    end

    assign stall     = stall_s;
    assign fwd_ex    = fwd_ex_r;
    assign stall_cnt = stall_cnt_r;

    // Advance every entry one stage; the last stage retires, slot 0 takes ID or a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_valid_r <= {DEPTH{1'b0}};
            ent_dst_r   <= {(DEPTH*REG_AW){1'b0}};
            ent_rdy_r   <= {(DEPTH*SW){1'b0}};
        end else begin
            ent_valid_r <= {ent_valid_r[DEPTH-2:0], load_s};
            ent_dst_r   <= {ent_dst_r[(DEPTH-1)*REG_AW-1:0], id_dst};
            ent_rdy_r   <= {ent_rdy_r[(DEPTH-1)*SW-1:0], id_rdy_stg};
        end
    end

    // EXE operand selects; a bubble enters EXE on stall or flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fwd_ex_r <= {(NUM_SRC*FW){1'b0}};
        end else if (stall_s || flush) begin
            fwd_ex_r <= {(NUM_SRC*FW){1'b0}};
        end else begin
            fwd_ex_r <= fwd_ex_nxt_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Randomized scoreboard bench: a forwarding instance and a no-forwarding
// instance (narrow counter) share stimulus and are compared to an
// age-based model of the in-flight instructions.
module tb_pipe_scoreboard;

    localparam int NCYC = 420;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_en;
    logic [1:0]  id_src_use_id;
    logic        id_wr;
    logic [4:0]  id_dst;
    logic [1:0]  id_rdy_stg;
    logic        flush;

    logic        stall_a, stall_b;
    logic [3:0]  fwd_id_a, fwd_id_b, fwd_ex_a, fwd_ex_b;
    logic [15:0] stall_cnt_a;
    logic [2:0]  stall_cnt_b;

    pipe_scoreboard #(.FWD_EN(1), .CNT_W(16)) u_fwd (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_en(id_src_en), .id_src_use_id(id_src_use_id), .id_wr(id_wr),
        .id_dst(id_dst), .id_rdy_stg(id_rdy_stg), .flush(flush),
        .stall(stall_a), .fwd_id(fwd_id_a), .fwd_ex(fwd_ex_a), .stall_cnt(stall_cnt_a)
    );

    pipe_scoreboard #(.FWD_EN(0), .CNT_W(3)) u_nofwd (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_en(id_src_en), .id_src_use_id(id_src_use_id), .id_wr(id_wr),
        .id_dst(id_dst), .id_rdy_stg(id_rdy_stg), .flush(flush),
        .stall(stall_b), .fwd_id(fwd_id_b), .fwd_ex(fwd_ex_b), .stall_cnt(stall_cnt_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: in-flight writers with their age (0 = EXE) per instance mode.
    typedef struct {
        int mode;
        int dst;
        int rdy;
        int age;
    } infl_t;

    typedef struct {
        logic        st0, st1;
        logic [3:0]  fid0, fid1, fex0, fex1;
        logic [15:0] c0;
        logic [2:0]  c1;
    } exp_t;

    infl_t fl[$];
    exp_t  expq[$];
    int    cnt_m[2];
    int    cnt_max[2];
    logic [3:0] fex_m[2];
    logic       cur_st[2];
    logic [3:0] cur_fid[2];
    logic [3:0] cur_fexn[2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Spec rules applied to the youngest in-flight writer of each source.
    function automatic void eval(input int m, output logic st, output logic [3:0] fid,
                                 output logic [3:0] fexn);
        logic hz;
        int   best_age;
        int   best_rdy;
        int   src;
        hz   = 1'b0;
        fid  = 4'd0;
        fexn = 4'd0;
        for (int s = 0; s < 2; s++) begin
            src      = int'(id_src[s*5 +: 5]);
            best_age = -1;
            best_rdy = 0;
            foreach (fl[i]) begin
                if (fl[i].mode == m && id_src_en[s] && fl[i].dst == src &&
                    (best_age < 0 || fl[i].age < best_age)) begin
                    best_age = fl[i].age;
                    best_rdy = fl[i].rdy;
                end
            end
            if (best_age >= 0) begin
                if (m == 1) begin
                    hz = 1'b1;
                end else if (id_src_use_id[s]) begin
                    if (best_age < best_rdy) hz = 1'b1;
                    else fid[s*2 +: 2] = 2'(best_age + 1);
                end else begin
                    if (best_age + 1 < best_rdy) hz = 1'b1;
                    else if (best_age + 1 <= 2) fexn[s*2 +: 2] = 2'(best_age + 2);
                end
            end
        end
        st = id_valid & ~flush & hz;
    endfunction

    task automatic model_reset();
        fl.delete();
        for (int m = 0; m < 2; m++) begin
            cnt_m[m] = 0;
            fex_m[m] = 4'd0;
        end
    endtask

    // One clock edge with the inputs that were present at that edge.
    task automatic model_clock();
        infl_t nq[$];
        infl_t e;
        for (int m = 0; m < 2; m++) begin
            fex_m[m] = (cur_st[m] || flush) ? 4'd0 : cur_fexn[m];
            if (cur_st[m] && cnt_m[m] < cnt_max[m]) cnt_m[m]++;
        end
        foreach (fl[i]) begin
            if (fl[i].age + 1 < 3) begin
                e = fl[i];
                e.age = e.age + 1;
                nq.push_back(e);
            end
        end
        fl = nq;
        for (int m = 0; m < 2; m++) begin
            if (id_valid && id_wr && id_dst != 5'd0 && !cur_st[m] && !flush) begin
                e.mode = m;
                e.dst  = int'(id_dst);
                e.rdy  = int'(id_rdy_stg);
                e.age  = 0;
                fl.push_back(e);
            end
        end
    endtask

    // Monitor: compare every presented output set against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall_fwd",     {15'd0, stall_a},     {15'd0, e.st0});
                chk("fwd_id_fwd",    {12'd0, fwd_id_a},    {12'd0, e.fid0});
                chk("fwd_ex_fwd",    {12'd0, fwd_ex_a},    {12'd0, e.fex0});
                chk("stall_cnt_fwd", stall_cnt_a,          e.c0);
                chk("stall_nofwd",   {15'd0, stall_b},     {15'd0, e.st1});
                chk("fwd_id_nofwd",  {12'd0, fwd_id_b},    {12'd0, e.fid1});
                chk("fwd_ex_nofwd",  {12'd0, fwd_ex_b},    {12'd0, e.fex1});
                chk("stall_cnt_nofwd", {13'd0, stall_cnt_b}, {13'd0, e.c1});
            end
        end
    end

    // Driver: randomized ID traffic over a small register set to force dependences.
    initial begin
        exp_t e;
        cnt_max[0] = 65535;
        cnt_max[1] = 7;
        reset = 1'b0;
        id_valid = 1'b0; id_src = 10'd0; id_src_en = 2'd0; id_src_use_id = 2'd0;
        id_wr = 1'b0; id_dst = 5'd0; id_rdy_stg = 2'd1; flush = 1'b0;
        for (int m = 0; m < 2; m++) begin
            cur_st[m] = 1'b0; cur_fid[m] = 4'd0; cur_fexn[m] = 4'd0;
        end
        model_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clock);
            #1;
            if (reset) model_clock();
            reset         = !(cyc < 2 || (cyc >= 200 && cyc < 203));
            id_valid      = ($urandom_range(0, 7) != 0);
            id_src[4:0]   = 5'($urandom_range(0, 3));
            id_src[9:5]   = 5'($urandom_range(0, 3));
            id_src_en     = 2'($urandom_range(0, 3));
            id_src_use_id = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            id_wr         = ($urandom_range(0, 3) != 0);
            id_dst        = 5'($urandom_range(0, 3));
            id_rdy_stg    = ($urandom_range(0, 2) == 0) ? 2'd2 : 2'd1;
            flush         = ($urandom_range(0, 9) == 0);
            if (!reset) model_reset();
            for (int m = 0; m < 2; m++) eval(m, cur_st[m], cur_fid[m], cur_fexn[m]);
            e.st0  = cur_st[0];
            e.st1  = cur_st[1];
            e.fid0 = cur_fid[0];
            e.fid1 = cur_fid[1];
            e.fex0 = fex_m[0];
            e.fex1 = fex_m[1];
            e.c0   = 16'(cnt_m[0]);
            e.c1   = 3'(cnt_m[1]);
            expq.push_back(e);
        end
        repeat (2) @(posedge clock);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
